data_mem_ctrl: RTL and testbench

// - Sole owner of the 4 KB byte-addressed data memory (Memoria32Data) port.
// - Shares it between the core load/store unit (LSU) and the debug memory loader.
// - Builds byte-lane write masks; formats and sign-extends load data.
// - Flags out-of-range accesses; sequences hand-over between normal and debug (init) mode.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_load_fmt.sv | 23 ++
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: funct3 codes,
// controller state enum, access size / legality / store mask helpers.
// Ports: none (constants, types and functions only).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_BYTES_DEF = 4096;
  localparam int unsigned DBG_CNT_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_CORE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DEBUG = 2'd2
  } dmem_state_t;

  // Bytes touched by an access; funct3[1:0] encodes the width.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Stores have no unsigned variants; loads reject 011 and 11x.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    f3_legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B:    store_mask = 4'b0001;
      F3_H:    store_mask = 4'b0011;
      F3_W:    store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load data formatter: selects/extends bytes of a memory word per funct3.
// Ports: funct3_i (load type), dataout_i (raw word, byte 0 in [7:0]),
//        rdata_o (formatted result). Purely combinational, no latency.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] dataout_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = dataout_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{dataout_i[7]}}, dataout_i[7:0]};
      F3_BU:   rdata_o = {24'd0, dataout_i[7:0]};
      F3_H:    rdata_o = {{16{dataout_i[15]}}, dataout_i[15:0]};
      F3_HU:   rdata_o = {16'd0, dataout_i[15:0]};
      default: rdata_o = dataout_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory port owner: arbitrates LSU vs debug loader, builds write masks,
// formats loads (rvalid 1 cycle after grant), flags out-of-range accesses.
// Ports: clk/reset, core_* (LSU req/gnt/rvalid), dbg_* (loader beats),
//        mem_* (memory port). Debug ownership wins; core is stalled via gnt=0.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned DBG_CNT_W = DBG_CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic [2:0]           core_funct3_i,
  input  logic [31:0]          core_addr_i,
  input  logic [31:0]          core_wdata_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  output logic [31:0]          core_rdata_o,
  output logic                 core_fault_o,
  input  logic                 dbg_mode_i,
  input  logic                 dbg_valid_i,
  input  logic [31:0]          dbg_addr_i,
  input  logic [31:0]          dbg_wdata1_i,
  input  logic [31:0]          dbg_wdata2_i,
  output logic                 dbg_ready_o,
  output logic                 dbg_active_o,
  output logic                 dbg_err_o,
  output logic [DBG_CNT_W-1:0] dbg_count_o,
  output logic [31:0]          mem_address_o,
  output logic [31:0]          mem_datain1_o,
  output logic [31:0]          mem_datain2_o,
  output logic [3:0]           mem_wr_o,
  output logic                 mem_enable_debug_o,
  input  logic [31:0]          mem_dataout_i
);

  localparam logic [32:0] MEM_END = 33'(MEM_BYTES);

  dmem_state_t          state_q, state_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [2:0]           rd_funct3_q, rd_funct3_d;
  logic                 rd_fault_q, rd_fault_d;
  logic [DBG_CNT_W-1:0] dbg_count_q, dbg_count_d;
  logic                 dbg_err_q, dbg_err_d;

  logic [32:0] core_last, dbg_last;
  logic        core_bad, dbg_bad;
  logic [31:0] fmt_rdata;

  // 33-bit sums so addresses near 2^32 cannot wrap back into range.
  assign core_last = {1'b0, core_addr_i} + {30'd0, size_of(core_funct3_i)} - 33'd1;
  assign core_bad  = !f3_legal(core_we_i, core_funct3_i) || (core_last >= MEM_END);
  assign dbg_last  = {1'b0, dbg_addr_i} + 33'd7;
  assign dbg_bad   = (dbg_addr_i[1:0] != 2'b00) || (dbg_last >= MEM_END);

  dmem_load_fmt u_fmt (
    .funct3_i  (rd_funct3_q),
    .dataout_i (mem_dataout_i),
    .rdata_o   (fmt_rdata)
  );

  always_comb begin
    state_d            = state_q;
    rd_pending_d       = 1'b0;
    rd_funct3_d        = rd_funct3_q;
    rd_fault_d         = 1'b0;
    dbg_count_d        = dbg_count_q;
    dbg_err_d          = dbg_err_q;
    core_gnt_o         = 1'b0;
    mem_address_o      = '0;
    mem_datain1_o      = '0;
    mem_datain2_o      = '0;
    mem_wr_o           = 4'b0000;
    mem_enable_debug_o = 1'b0;
    dbg_active_o       = 1'b0;
    dbg_ready_o        = 1'b0;
    core_rvalid_o      = rd_pending_q;
    core_rdata_o       = (rd_pending_q && !rd_fault_q) ? fmt_rdata : '0;
    core_fault_o       = rd_pending_q && rd_fault_q;
    dbg_count_o        = dbg_count_q;
    dbg_err_o          = dbg_err_q;

    case (state_q)
      ST_CORE: begin
        if (dbg_mode_i) begin
          state_d = ST_DRAIN;
        end else if (core_req_i) begin
          core_gnt_o    = 1'b1;
          mem_address_o = core_addr_i;
          if (core_we_i) begin
            mem_datain1_o = core_wdata_i;
            mem_wr_o      = core_bad ? 4'b0000 : store_mask(core_funct3_i);
            core_fault_o  = core_fault_o | core_bad;
          end else begin
            rd_pending_d = 1'b1;
            rd_funct3_d  = core_funct3_i;
            rd_fault_d   = core_bad;
          end
        end
      end
      ST_DRAIN: begin
        if (!rd_pending_q) begin
          state_d     = ST_DEBUG;
          dbg_count_d = '0;
          dbg_err_d   = 1'b0;
        end
      end
      ST_DEBUG: begin
        mem_enable_debug_o = 1'b1;
        dbg_active_o       = 1'b1;
        if (dbg_valid_i) begin
          dbg_ready_o   = 1'b1;
          mem_address_o = dbg_addr_i;
          mem_datain1_o = dbg_wdata1_i;
          mem_datain2_o = dbg_wdata2_i;
          if (dbg_bad) begin
            dbg_err_d = 1'b1;
          end else begin
            mem_wr_o    = 4'b1111;
            dbg_count_d = dbg_count_q + DBG_CNT_W'(1);
          end
        end
        if (!dbg_mode_i) state_d = ST_CORE;
      end
      default: state_d = ST_CORE;
    endcase

    // Quiet every output while reset is asserted so no write lands on the reset edge.
    if (!reset_n_i) begin
      core_gnt_o         = 1'b0;
      core_rvalid_o      = 1'b0;
      core_rdata_o       = '0;
      core_fault_o       = 1'b0;
      mem_address_o      = '0;
      mem_datain1_o      = '0;
      mem_datain2_o      = '0;
      mem_wr_o           = 4'b0000;
      mem_enable_debug_o = 1'b0;
      dbg_active_o       = 1'b0;
      dbg_ready_o        = 1'b0;
      dbg_count_o        = '0;
      dbg_err_o          = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_CORE;
      rd_pending_q <= 1'b0;
      rd_funct3_q  <= 3'b000;
      rd_fault_q   <= 1'b0;
      dbg_count_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      rd_funct3_q  <= rd_funct3_d;
      rd_fault_q   <= rd_fault_d;
      dbg_count_q  <= dbg_count_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: memory emulator, spec-level reference model,
// directed literal scenarios and a randomized phase.
module tb_data_mem_ctrl;

  localparam int MB = 4096;
  localparam int M_CORE = 0, M_DRAIN = 1, M_DEBUG = 2;

  logic        clk = 1'b0;
  logic        reset_n, core_req, core_we, dbg_mode, dbg_valid;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata1, dbg_wdata2;
  logic        core_gnt, core_rvalid, core_fault, dbg_ready, dbg_active, dbg_err, mem_en;
  logic [31:0] core_rdata, mem_address, mem_d1, mem_d2;
  logic [31:0] mem_dataout = 32'd0;
  logic [3:0]  mem_wr;
  logic [9:0]  dbg_count;

  int n_chk = 0, n_err = 0;

  data_mem_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_funct3_i(core_funct3),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .core_fault_o(core_fault),
    .dbg_mode_i(dbg_mode), .dbg_valid_i(dbg_valid), .dbg_addr_i(dbg_addr),
    .dbg_wdata1_i(dbg_wdata1), .dbg_wdata2_i(dbg_wdata2),
    .dbg_ready_o(dbg_ready), .dbg_active_o(dbg_active), .dbg_err_o(dbg_err),
    .dbg_count_o(dbg_count),
    .mem_address_o(mem_address), .mem_datain1_o(mem_d1), .mem_datain2_o(mem_d2),
    .mem_wr_o(mem_wr), .mem_enable_debug_o(mem_en), .mem_dataout_i(mem_dataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- memory emulator (environment, driven by DUT outputs) ----
  logic [7:0]  emu_mem [0:MB-1];
  logic [31:0] l_addr, l_d1, l_d2;
  logic [3:0]  l_wr;
  logic        l_en;

  always @(negedge clk) begin
    l_addr = mem_address; l_d1 = mem_d1; l_d2 = mem_d2; l_wr = mem_wr; l_en = mem_en;
  end

  always @(posedge clk) begin
    logic [31:0] w;
    if (l_en && l_wr == 4'hF) begin
      for (int i = 0; i < 8; i++)
        if (longint'(l_addr) + i < MB)
          emu_mem[l_addr + i] = (i < 4) ? l_d1[8*i +: 8] : l_d2[8*(i-4) +: 8];
    end else begin
      for (int i = 0; i < 4; i++)
        if (l_wr[i] && longint'(l_addr) + i < MB) emu_mem[l_addr + i] = l_d1[8*i +: 8];
    end
    w = 32'd0;
    for (int i = 0; i < 4; i++)
      if (longint'(l_addr) + i < MB) w[8*i +: 8] = emu_mem[l_addr + i];
    mem_dataout <= w;
  end

  // ---------------- reference model ----------------------------------------
  logic [7:0] ref_mem [0:MB-1];
  int         m_mode = M_CORE, m_cnt = 0;
  bit         m_err = 0, m_pv = 0, m_pflt = 0;
  logic [31:0] m_prd = 0;

  function automatic bit acc_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz; bit legal;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
    return !legal || (longint'(a) + sz > MB);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    case (f3)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd4: return {24'd0, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd5: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    logic e_gnt, e_rv, e_flt, e_en, e_act, e_rdy, e_err, flt, st, dw;
    logic [3:0]  e_wr;
    logic [31:0] e_addr, e_d1, e_d2, e_rd;
    int e_cnt, n_mode, n_cnt; bit n_err_b, n_pv, n_pflt; logic [31:0] n_prd;
    e_gnt = 0; e_rv = 0; e_flt = 0; e_en = 0; e_act = 0; e_rdy = 0; e_err = 0;
    e_wr = 0; e_addr = 0; e_d1 = 0; e_d2 = 0; e_rd = 0; e_cnt = 0;
    st = 0; dw = 0;
    n_mode = M_CORE; n_cnt = 0; n_err_b = 0; n_pv = 0; n_pflt = 0; n_prd = 0;
    if (reset_n) begin
      e_rv = m_pv; e_rd = m_prd; e_flt = m_pv && m_pflt; e_cnt = m_cnt; e_err = m_err;
      n_mode = m_mode; n_cnt = m_cnt; n_err_b = m_err;
      if (m_mode == M_CORE) begin
        if (dbg_mode) n_mode = M_DRAIN;
        else if (core_req) begin
          e_gnt = 1; e_addr = core_addr;
          flt = acc_fault(core_we, core_funct3, core_addr);
          if (core_we) begin
            e_d1 = core_wdata; e_flt = e_flt | flt;
            if (!flt) begin
              e_wr = (core_funct3 == 0) ? 4'h1 : (core_funct3 == 1) ? 4'h3 : 4'hF;
              st = 1;
            end
          end else begin
            n_pv = 1; n_pflt = flt; n_prd = flt ? 32'd0 : load_val(core_funct3, core_addr);
          end
        end
      end else if (m_mode == M_DRAIN) begin
        if (!m_pv) begin n_mode = M_DEBUG; n_cnt = 0; n_err_b = 0; end
      end else begin
        e_en = 1; e_act = 1;
        if (dbg_valid) begin
          e_rdy = 1; e_addr = dbg_addr; e_d1 = dbg_wdata1; e_d2 = dbg_wdata2;
          if (dbg_addr[1:0] != 0 || longint'(dbg_addr) + 7 >= MB) n_err_b = 1;
          else begin e_wr = 4'hF; dw = 1; n_cnt = (m_cnt + 1) % 1024; end
        end
        if (!dbg_mode) n_mode = M_CORE;
      end
    end
    chk("gnt", core_gnt, e_gnt);
    chk("rvalid", core_rvalid, e_rv);
    chk("rdata", core_rdata, e_rd);
    chk("fault", core_fault, e_flt);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_addr", mem_address, e_addr);
    chk("datain1", mem_d1, e_d1);
    chk("datain2", mem_d2, e_d2);
    chk("en_debug", mem_en, e_en);
    chk("dbg_active", dbg_active, e_act);
    chk("dbg_ready", dbg_ready, e_rdy);
    chk("dbg_count", dbg_count, e_cnt[9:0]);
    chk("dbg_err", dbg_err, e_err);
    if (st) for (int i = 0; i < 4; i++) if (e_wr[i]) ref_mem[core_addr + i] = core_wdata[8*i +: 8];
    if (dw) for (int i = 0; i < 8; i++)
      ref_mem[dbg_addr + i] = (i < 4) ? dbg_wdata1[8*i +: 8] : dbg_wdata2[8*(i-4) +: 8];
    m_mode = n_mode; m_cnt = n_cnt; m_err = n_err_b; m_pv = n_pv; m_pflt = n_pflt; m_prd = n_prd;
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic at_neg(); @(negedge clk); endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0;
    dbg_valid = 0; dbg_addr = 0; dbg_wdata1 = 0; dbg_wdata2 = 0;
  endtask

  task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    idle(); core_req = 1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 63));
      6, 7:             return 32'($urandom_range(4080, 4095));
      8:                return 32'($urandom_range(4096, 4100));
      default:          return $urandom;
    endcase
  endfunction

  logic [31:0] beat3_d2;
  bit want_dbg;

  initial begin
    for (int i = 0; i < MB; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      ref_mem[i] = b; emu_mem[i] = b;
    end
    reset_n = 0; dbg_mode = 0;
    core_op(1, 3'd2, 32'h100, 32'h1);
    at_neg(); chk("rst_gnt", core_gnt, 0); chk("rst_wr", mem_wr, 0); step();
    step();
    reset_n = 1;

    // store/load round trip
    core_op(1, 3'd2, 32'h100, 32'hDEADBEEF);
    at_neg(); chk("sw_gnt", core_gnt, 1); chk("sw_wr", mem_wr, 4'hF); chk("sw_fault", core_fault, 0); step();
    core_op(0, 3'd2, 32'h100, 0);
    at_neg(); chk("lw_gnt", core_gnt, 1); step();
    idle();
    at_neg(); chk("lw_rv", core_rvalid, 1); chk("lw_data", core_rdata, 32'hDEADBEEF);
    chk("lw_fault", core_fault, 0); step();

    // byte store, signed/unsigned byte loads back to back
    core_op(1, 3'd0, 32'h103, 32'h80);
    at_neg(); chk("sb_wr", mem_wr, 4'h1); step();
    core_op(0, 3'd0, 32'h103, 0); step();
    core_op(0, 3'd4, 32'h103, 0);
    at_neg(); chk("lb_data", core_rdata, 32'hFFFFFF80); step();
    idle();
    at_neg(); chk("lbu_data", core_rdata, 32'h00000080); step();

    // out-of-range accesses
    core_op(0, 3'd1, 32'hFFF, 0); step();
    core_op(0, 3'd2, 32'hFFD, 0);
    at_neg(); chk("lh_fault", core_fault, 1); chk("lh_data", core_rdata, 0); step();
    core_op(1, 3'd2, 32'h1000, 32'h12345678);
    at_neg(); chk("lw_oob_data", core_rdata, 0); chk("sw_oob_fault", core_fault, 1);
    chk("sw_oob_wr", mem_wr, 0); step();
    core_op(0, 3'd2, 32'hFFC, 0);
    at_neg(); chk("lw_top_gnt", core_gnt, 1); chk("lw_top_nofault", core_fault, 0); step();
    idle();
    at_neg(); chk("lw_top_rv", core_rvalid, 1); chk("lw_top_fault", core_fault, 0); step();

    // hand-over to debug with a read in flight
    core_op(0, 3'd2, 32'h20, 0); step();
    dbg_mode = 1; core_op(0, 3'd2, 32'h24, 0);
    at_neg(); chk("dbg_rise_gnt", core_gnt, 0); chk("dbg_rise_rv", core_rvalid, 1); step();
    idle();
    at_neg(); chk("drain_active", dbg_active, 0); step();
    at_neg(); chk("debug_active", dbg_active, 1); chk("debug_en", mem_en, 1); step();

    for (int k = 0; k < 3; k++) begin
      idle(); dbg_valid = 1; dbg_addr = 32'(8 * k);
      dbg_wdata1 = $urandom; dbg_wdata2 = $urandom; beat3_d2 = dbg_wdata2;
      at_neg(); chk("beat_ready", dbg_ready, 1); chk("beat_wr", mem_wr, 4'hF);
      chk("beat_cnt", dbg_count, 10'(k)); step();
    end
    idle(); dbg_valid = 1; dbg_addr = 32'h6;
    at_neg(); chk("bad_cnt", dbg_count, 3); chk("bad_ready", dbg_ready, 1); chk("bad_wr", mem_wr, 0); step();
    idle(); dbg_mode = 0;
    at_neg(); chk("bad_err", dbg_err, 1); chk("bad_cnt2", dbg_count, 3); step();
    core_op(0, 3'd2, 32'h14, 0);
    at_neg(); chk("back_gnt", core_gnt, 1); chk("back_active", dbg_active, 0); step();
    idle();
    at_neg(); chk("back_data", core_rdata, beat3_d2); step();

    // reset in the middle of debug
    dbg_mode = 1; step(); step();
    dbg_valid = 1; dbg_addr = 32'h30; dbg_wdata1 = $urandom; dbg_wdata2 = $urandom;
    at_neg(); chk("rst2_active", dbg_active, 1); step();
    dbg_addr = 32'h40; reset_n = 0;
    at_neg(); chk("rst2_wr", mem_wr, 0); chk("rst2_ready", dbg_ready, 0); step();
    reset_n = 1; dbg_mode = 0;
    at_neg(); chk("rst2_state", dbg_active, 0); chk("rst2_cnt", dbg_count, 0);
    chk("rst2_wr_after", mem_wr, 0); chk("rst2_rv", core_rvalid, 0); step();

    // randomized traffic; the model checks every cycle
    want_dbg = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] f3;
      if ($urandom_range(0, 79) == 0) want_dbg = !want_dbg;
      dbg_mode = want_dbg;
      reset_n = ($urandom_range(0, 699) != 0);
      f3 = 3'($urandom_range(0, 7));
      if ((f3 == 3'd3 || f3 >= 3'd6) && $urandom_range(0, 3) != 0) f3 = 3'd2;
      core_req = ($urandom_range(0, 2) != 0);
      core_we = 1'($urandom_range(0, 1));
      core_funct3 = f3;
      core_addr = rand_addr();
      core_wdata = $urandom;
      dbg_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       dbg_addr = 32'($urandom_range(1016, 1023) * 4);
        1:       dbg_addr = 32'($urandom_range(0, 127));
        default: dbg_addr = 32'($urandom_range(0, 31) * 4);
      endcase
      dbg_wdata1 = $urandom; dbg_wdata2 = $urandom;
      step();
    end
    reset_n = 1; dbg_mode = 0; idle(); step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
